adc_capture_sequencer: RTL and testbench

Capture controller between the multi-channel hydrophone ADC driver and the shared sample FIFO. On a start command it accepts a fixed number of samples per channel, buffers one sample per channel, and round-robin arbitrates the buffered samples onto the FIFO's single write port, tagging each with its channel index. It reports completion, per-channel overruns and a written-sample count to the host-side logic.

---
 rtl/adc_capture_pkg.sv | 21 ++
 rtl/adc_capture_sequencer_rr_arbiter.sv | 48 ++++
 rtl/adc_capture_sequencer.sv | 158 +++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
// No logic; state encoding and width helper only.
// Imported by the top and the arbiter.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAME_W    = 20;

    // Channel index width, never below one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_capture_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// Latency: combinational grant; pointer advances past the winner at the next edge.
// Backpressure: en low blocks every grant and freezes the pointer.
module rr_arbiter
    import adc_capture_pkg::*;
#(
    parameter int N  = DEF_NUM_CH,
    parameter int IW = ch_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          clr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx;

    // N is a power of two, so the index add wraps naturally.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + IW'(i);
            if (!gnt_vld && en && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (gnt_vld) begin
            ptr_q <= gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Captures a fixed number of samples per ADC channel into single-entry holds and
// round-robins them onto one FIFO write port; write is combinational, one cycle after the strobe.
// Backpressure: fifo_full stalls grants; a strobe onto an occupied, ungranted hold is dropped and flagged.
module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAME_W    = DEF_FRAME_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic [FRAME_W-1:0]                 frames,
    input  logic [NUM_CH-1:0]                  ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]       ch_data,
    input  logic                               fifo_full,
    output logic                               fifo_write,
    output logic [DATA_WIDTH-1:0]              fifo_wdata,
    output logic [ch_w(NUM_CH)-1:0]            fifo_wchan,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_CH-1:0]                  overrun,
    output logic [FRAME_W+ch_w(NUM_CH)-1:0]    samples_written
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int SW_W = FRAME_W + CH_W;

    state_t state, state_nxt;

    logic [FRAME_W-1:0]    frames_q;
    logic [FRAME_W-1:0]    cnt_q        [NUM_CH];
    logic [FRAME_W-1:0]    cnt_nxt      [NUM_CH];
    logic [DATA_WIDTH-1:0] hold_dat_q   [NUM_CH];
    logic [DATA_WIDTH-1:0] hold_dat_nxt [NUM_CH];
    logic [NUM_CH-1:0]     hold_vld_q, hold_vld_nxt;
    logic [NUM_CH-1:0]     ovr_q, ovr_nxt;
    logic [SW_W-1:0]       sw_q, sw_nxt;

    logic                  arb_en;
    logic [NUM_CH-1:0]     gnt;
    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_vld;
    logic                  start_go;
    logic                  all_done;

    assign start_go = (state == IDLE) && start && (frames != '0);
    assign arb_en   = (state == CAPTURE) && !fifo_full && !abort;

    rr_arbiter #(.N(NUM_CH), .IW(CH_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (hold_vld_q),
        .en      (arb_en),
        .clr     (start_go),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Per-channel accounting; completion looks at next-state values so done
    // follows the last write by exactly one cycle.
    always_comb begin
        cnt_nxt      = cnt_q;
        hold_dat_nxt = hold_dat_q;
        hold_vld_nxt = hold_vld_q;
        ovr_nxt      = ovr_q;
        sw_nxt       = sw_q;
        all_done     = 1'b1;
        if (start_go) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_nxt[i]      = '0;
                hold_dat_nxt[i] = '0;
            end
            hold_vld_nxt = '0;
            ovr_nxt      = '0;
            sw_nxt       = '0;
        end else if (state == CAPTURE) begin
            if (abort) begin
                hold_vld_nxt = '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (gnt[i]) begin
                        hold_vld_nxt[i] = 1'b0;
                    end
                    if (ch_valid[i] && (cnt_q[i] < frames_q)) begin
                        cnt_nxt[i] = cnt_q[i] + FRAME_W'(1);
                        if (!hold_vld_q[i] || gnt[i]) begin
                            hold_vld_nxt[i] = 1'b1;
                            hold_dat_nxt[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            ovr_nxt[i] = 1'b1;
                        end
                    end
                end
                sw_nxt = sw_q + SW_W'(gnt_vld);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_nxt[i] != frames_q) begin
                all_done = 1'b0;
            end
        end
        if (hold_vld_nxt != '0) begin
            all_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frames_q   <= '0;
            hold_vld_q <= '0;
            ovr_q      <= '0;
            sw_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                hold_dat_q[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            hold_vld_q <= hold_vld_nxt;
            ovr_q      <= ovr_nxt;
            sw_q       <= sw_nxt;
            cnt_q      <= cnt_nxt;
            hold_dat_q <= hold_dat_nxt;
            if (start_go) begin
                frames_q <= frames;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (frames != '0) ? CAPTURE : DONE;
            CAPTURE: begin
                if (abort)         state_nxt = IDLE;
                else if (all_done) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state == CAPTURE);
        done            = (state == DONE);
        fifo_write      = gnt_vld;
        fifo_wdata      = gnt_vld ? hold_dat_q[gnt_idx] : '0;
        fifo_wchan      = gnt_vld ? gnt_idx : '0;
        overrun         = ovr_q;
        samples_written = sw_q;
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: hand-computed expectations per scenario.
module tb_adc_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] frames = '0;
    logic [3:0]  ch_valid = '0;
    logic [63:0] ch_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_write;
    logic [15:0] fifo_wdata;
    logic [1:0]  fifo_wchan;
    logic        busy;
    logic        done;
    logic [3:0]  overrun;
    logic [21:0] samples_written;

    adc_capture_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .frames          (frames),
        .ch_valid        (ch_valid),
        .ch_data         (ch_data),
        .fifo_full       (fifo_full),
        .fifo_write      (fifo_write),
        .fifo_wdata      (fifo_wdata),
        .fifo_wchan      (fifo_wchan),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .samples_written (samples_written)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          wr_cyc [$];
    logic [15:0] wr_dat [$];
    logic [1:0]  wr_ch  [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (fifo_write) begin
                wr_cyc.push_back(cyc);
                wr_dat.push_back(fifo_wdata);
                wr_ch.push_back(fifo_wchan);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] qd(input int k);
        return (k < wr_dat.size()) ? wr_dat[k] : 16'hDEAD;
    endfunction
    function automatic logic [1:0] qc(input int k);
        return (k < wr_ch.size()) ? wr_ch[k] : 2'bxx;
    endfunction
    function automatic int qy(input int k);
        return (k < wr_cyc.size()) ? wr_cyc[k] : -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [15:0] d);
        ch_data[i*16 +: 16] = d;
    endtask

    task automatic start_cap(input logic [19:0] fr);
        start  = 1'b1;
        frames = fr;
        tick();
        start  = 1'b0;
    endtask

    int base, dbase;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_fifo_write", 64'(fifo_write), 64'd0);
        chk("rst_fifo_wdata", 64'(fifo_wdata), 64'd0);
        chk("rst_fifo_wchan", 64'(fifo_wchan), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_samples", 64'(samples_written), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // T1: frames=3, one channel strobe per cycle, each channel once per 8 cycles
        base = wr_dat.size(); dbase = done_cnt;
        start_cap(20'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < 8; t++) begin
                ch_valid = '0;
                if (t < 4) begin
                    ch_valid[t] = 1'b1;
                    set_ch(t, 16'(16'h1000 + f*16 + t));
                end
                tick();
            end
        end
        ch_valid = '0;
        repeat (5) tick();
        chk("t1_nwrites", 64'(wr_dat.size() - base), 64'd12);
        for (int k = 0; k < 12; k++) begin
            chk("t1_chan", 64'(qc(base+k)), 64'(k % 4));
            chk("t1_data", 64'(qd(base+k)), 64'(16'h1000 + (k/4)*16 + (k%4)));
        end
        chk("t1_samples", 64'(samples_written), 64'd12);
        chk("t1_done_pulses", 64'(done_cnt - dbase), 64'd1);
        chk("t1_overrun", 64'(overrun), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // T2: all channels strobed together
        base = wr_dat.size(); dbase = done_cnt;
        start_cap(20'd1);
        ch_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_ch(i, 16'(16'hA000 + i));
        tick();
        ch_valid = '0;
        repeat (8) tick();
        chk("t2_nwrites", 64'(wr_dat.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_chan", 64'(qc(base+k)), 64'(k));
            chk("t2_data", 64'(qd(base+k)), 64'(16'hA000 + k));
            chk("t2_consecutive", 64'(qy(base+k) - qy(base)), 64'(k));
        end
        chk("t2_done_pulses", 64'(done_cnt - dbase), 64'd1);

        // T3: FIFO full 20 cycles, ch0 every 4 cycles
        base = wr_dat.size();
        start_cap(20'd8);
        fifo_full = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ch_valid = '0;
            if (c % 4 == 0) begin
                ch_valid[0] = 1'b1;
                set_ch(0, 16'(16'hB000 + c/4));
            end
            tick();
            if (c == 4) chk("t3_overrun_2nd", 64'(overrun), 64'd1);
        end
        ch_valid = '0;
        chk("t3_no_writes", 64'(wr_dat.size() - base), 64'd0);
        fifo_full = 1'b0;
        @(negedge clk);
        chk("t3_write_after", 64'(fifo_write), 64'd1);
        chk("t3_held_data", 64'(fifo_wdata), 64'hB000);
        chk("t3_held_chan", 64'(fifo_wchan), 64'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t3_busy_abort", 64'(busy), 64'd0);
        chk("t3_overrun_kept", 64'(overrun), 64'd1);
        chk("t3_samples", 64'(samples_written), 64'd1);
        tick();

        // T4: grant and new strobe on same channel in same cycle
        base = wr_dat.size(); dbase = done_cnt;
        start_cap(20'd2);
        ch_valid = 4'b0001; set_ch(0, 16'hC000);
        tick();
        ch_valid = 4'b0001; set_ch(0, 16'hC001);
        @(negedge clk);
        chk("t4_grant_same", 64'(fifo_wdata), 64'hC000);
        tick();
        ch_valid = 4'b1110;
        for (int i = 1; i < 4; i++) set_ch(i, 16'(16'hC010 + i));
        @(negedge clk);
        chk("t4_new_written", 64'(fifo_wdata), 64'hC001);
        chk("t4_new_write", 64'(fifo_write), 64'd1);
        tick();
        ch_valid = '0;
        repeat (3) tick();
        ch_valid = 4'b1110;
        for (int i = 1; i < 4; i++) set_ch(i, 16'(16'hC020 + i));
        tick();
        ch_valid = '0;
        repeat (6) tick();
        chk("t4_overrun", 64'(overrun), 64'd0);
        chk("t4_samples", 64'(samples_written), 64'd8);
        chk("t4_done_pulses", 64'(done_cnt - dbase), 64'd1);
        chk("t4_nwrites", 64'(wr_dat.size() - base), 64'd8);

        // T5: abort after five writes, then clean restart
        base = wr_dat.size(); dbase = done_cnt;
        start_cap(20'd4);
        for (int t = 0; t <= 10; t++) begin
            ch_valid = '0;
            if (t < 4) begin ch_valid[t] = 1'b1; set_ch(t, 16'(16'hD000 + t)); end
            if (t == 8) begin ch_valid[0] = 1'b1; set_ch(0, 16'hD008); end
            if (t == 9) begin ch_valid[1] = 1'b1; set_ch(1, 16'hD009); end
            if (t == 10) begin
                abort = 1'b1;
                @(negedge clk);
                chk("t5_abort_nowrite", 64'(fifo_write), 64'd0);
            end
            tick();
        end
        abort = 1'b0;
        ch_valid = '0;
        @(negedge clk);
        chk("t5_busy_after", 64'(busy), 64'd0);
        chk("t5_samples", 64'(samples_written), 64'd5);
        chk("t5_nwrites", 64'(wr_dat.size() - base), 64'd5);
        tick();
        tick();
        chk("t5_no_done", 64'(done_cnt - dbase), 64'd0);
        base = wr_dat.size();
        start_cap(20'd1);
        ch_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_ch(i, 16'(16'hE000 + i));
        tick();
        ch_valid = '0;
        repeat (7) tick();
        chk("t5r_nwrites", 64'(wr_dat.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t5r_chan", 64'(qc(base+k)), 64'(k));
            chk("t5r_data", 64'(qd(base+k)), 64'(16'hE000 + k));
        end
        chk("t5r_samples", 64'(samples_written), 64'd4);
        chk("t5r_done_pulses", 64'(done_cnt - dbase), 64'd1);

        // T6: frames=0 goes straight to done
        base = wr_dat.size();
        start_cap(20'd0);
        @(negedge clk);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        chk("t6_done_fall", 64'(done), 64'd0);
        chk("t6_nwrites", 64'(wr_dat.size() - base), 64'd0);
        tick();

        // T7: async reset mid-capture
        start_cap(20'd5);
        ch_valid = 4'b0001; set_ch(0, 16'hF000);
        tick();
        ch_valid = 4'b0001; set_ch(0, 16'hF001);
        tick();
        ch_valid = '0;
        @(negedge clk);
        chk("t7_pre_write", 64'(fifo_write), 64'd1);
        chk("t7_pre_samples", 64'(samples_written), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_write", 64'(fifo_write), 64'd0);
        chk("t7_rst_wdata", 64'(fifo_wdata), 64'd0);
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_samples", 64'(samples_written), 64'd0);
        chk("t7_rst_overrun", 64'(overrun), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
